// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory-side responder.
// Holds the FSM state enum, access-size masks and lane helpers.
package mem_resp_pkg;

  localparam int LANE_W = 2;

  localparam logic [3:0] MEM_MASK_B = 4'b0001;
  localparam logic [3:0] MEM_MASK_H = 4'b0011;
  localparam logic [3:0] MEM_MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  // Half on an odd lane or word on any non-zero lane.
  function automatic logic misaligned(
    input logic [3:0]        mask,
    input logic [LANE_W-1:0] lane
  );
    return ((mask == MEM_MASK_H) && lane[0]) ||
           ((mask == MEM_MASK_W) && (lane != '0));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane alignment: shifts store data/mask up and load data down.
// Ports: lane_i, wdata_i, wmask_i, rword_i -> wdata_o, wmask_o, rdata_o.
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  logic [LANE_W-1:0] lane_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wmask_i,
  input  logic [31:0]       rword_i,
  output logic [31:0]       wdata_o,
  output logic [3:0]        wmask_o,
  output logic [31:0]       rdata_o
);

  logic [4:0] bsh;

  assign bsh = {lane_i, 3'b000};

  assign wdata_o = wdata_i << bsh;
  // 4-bit result: enables pushed past byte 3 fall off.
  assign wmask_o = wmask_i << lane_i;
  assign rdata_o = rword_i >> bsh;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: one request at a time, fixed LATENCY, 1-cycle
// response pulse. Optional MEM_RESP_ERR_EN adds the mem_err port.
// Ports: clk, rst, mem_read_req_*/res_*, mem_write_req_*/res_*, mem_err.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_req_valid,
  input  logic [31:0] mem_read_req_addr,
  output logic        mem_read_res_valid,
  output logic [31:0] mem_read_res_data,
  input  logic        mem_write_req_valid,
  input  logic [31:0] mem_write_req_addr,
  input  logic [31:0] mem_write_req_data,
  input  logic [3:0]  mem_write_req_mask,
  output logic        mem_write_res_valid
`ifdef MEM_RESP_ERR_EN
  ,
  output logic        mem_err
`endif
);

  localparam int IDX_W =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [31:0] mem_q [DEPTH_WORDS];

  resp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             blk_wr_q, blk_wr_d;
  logic             blk_rd_q, blk_rd_d;

  logic              sel_wr;
  logic              acc_wr, acc_rd;
  logic [31:0]       addr, off;
  logic [LANE_W-1:0] lane;
  logic              in_rng, ok;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       wdata_sh, rdata_sh;
  logic [3:0]        wmask_sh;

  assign sel_wr = mem_write_req_valid && !blk_wr_q;
  assign acc_wr = (state_q == IDLE) && sel_wr;
  assign acc_rd = (state_q == IDLE) && !sel_wr &&
                  mem_read_req_valid && !blk_rd_q;

  assign addr   = sel_wr ? mem_write_req_addr
                         : mem_read_req_addr;
  assign off    = addr - BASE_ADDR;
  assign lane   = off[LANE_W-1:0];
  assign in_rng = off[31:2] < 30'(DEPTH_WORDS);
  assign idx    = off[IDX_W+1:2];

`ifdef MEM_RESP_ERR_EN
  logic err_q, err_d;
  logic bad;
  assign bad = misaligned(mem_write_req_mask, lane);
  assign ok  = in_rng && !bad;
`else
  assign ok  = in_rng;
`endif

  mem_lane_align u_align (
    .lane_i  (lane),
    .wdata_i (mem_write_req_data),
    .wmask_i (mem_write_req_mask),
    .rword_i (mem_q[idx]),
    .wdata_o (wdata_sh),
    .wmask_o (wmask_sh),
    .rdata_o (rdata_sh)
  );

  always_ff @(posedge clk) begin
    if (acc_wr && ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_sh[b])
          mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    blk_wr_d = 1'b0;
    blk_rd_d = 1'b0;
`ifdef MEM_RESP_ERR_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (acc_wr || acc_rd) begin
          wr_d    = acc_wr;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
          rdata_d = (acc_rd && ok) ? rdata_sh : '0;
`ifdef MEM_RESP_ERR_EN
          err_d   = !ok;
`endif
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        state_d  = IDLE;
        rdata_d  = '0;
        blk_wr_d = wr_q && mem_write_req_valid;
        blk_rd_d = !wr_q && mem_read_req_valid;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      blk_wr_q <= 1'b0;
      blk_rd_q <= 1'b0;
`ifdef MEM_RESP_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      blk_wr_q <= blk_wr_d;
      blk_rd_q <= blk_rd_d;
`ifdef MEM_RESP_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  assign mem_read_res_valid  = (state_q == RESP) && !wr_q;
  assign mem_write_res_valid = (state_q == RESP) && wr_q;
  assign mem_read_res_data   =
    mem_read_res_valid ? rdata_q : '0;
`ifdef MEM_RESP_ERR_EN
  assign mem_err = (state_q == RESP) && err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (LATENCY=2).
// Expected responses are queued at issue and popped on response.
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 4096;
  localparam logic [31:0] OOR   = DEPTH * 4;
  localparam logic [3:0]  F     = MEM_MASK_W;
`ifdef MEM_RESP_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  typedef struct packed {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] exp;
    logic        err;
  } op_t;

  // {kind, data, err, latency, one-cycle-wide}
  typedef logic [38:0] tup_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv = 1'b0, wv = 1'b0;
  logic [31:0] raddr = '0, waddr = '0, wdata = '0;
  logic [3:0]  wmask = '0;
  logic        rrv, wrv;
  logic [31:0] rdata;
  logic        err_sig;

  int cyc = 0;
  int n_rr = 0, n_wr = 0;
  int tests = 0, fails = 0;
  tup_t sb[$];

`ifdef MEM_RESP_ERR_EN
  logic mem_err;
  assign err_sig = mem_err;
`else
  assign err_sig = 1'b0;
`endif

  mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (32'h0),
    .LATENCY     (LAT),
    .INIT_FILE   ("")
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_read_req_valid  (rv),
    .mem_read_req_addr   (raddr),
    .mem_read_res_valid  (rrv),
    .mem_read_res_data   (rdata),
    .mem_write_req_valid (wv),
    .mem_write_req_addr  (waddr),
    .mem_write_req_data  (wdata),
    .mem_write_req_mask  (wmask),
    .mem_write_res_valid (wrv)
`ifdef MEM_RESP_ERR_EN
    ,
    .mem_err             (mem_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rrv) n_rr <= n_rr + 1;
    if (wrv) n_wr <= n_wr + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  function automatic op_t W(input logic [31:0] a,
                            input logic [31:0] d,
                            input logic [3:0]  m,
                            input logic        e);
    op_t o;
    o.wr = 1'b1; o.a = a; o.d = d; o.m = m;
    o.exp = '0; o.err = e;
    return o;
  endfunction

  function automatic op_t R(input logic [31:0] a,
                            input logic [3:0]  m,
                            input logic [31:0] x,
                            input logic        e);
    op_t o;
    o.wr = 1'b0; o.a = a; o.d = '0; o.m = m;
    o.exp = x; o.err = e;
    return o;
  endfunction

  task automatic issue(input op_t o);
    if (o.wr) begin
      wv = 1'b1; waddr = o.a;
      wdata = o.d; wmask = o.m;
    end else begin
      rv = 1'b1; raddr = o.a; wmask = o.m;
    end
    sb.push_back({o.wr, o.exp, o.err, 4'(LAT), 1'b1});
  endtask

  task automatic drop(input logic is_wr);
    if (is_wr) wv = 1'b0;
    else rv = 1'b0;
  endtask

  task automatic wait_resp(input int hold,
                           output logic gw,
                           output logic [31:0] gd,
                           output logic ge,
                           output int at,
                           output logic nar,
                           output bit to);
    to = 1'b1; gw = 1'b0; gd = '0;
    ge = 1'b0; at = 0; nar = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rrv || wrv) begin
        to = 1'b0; gw = wrv; gd = rdata;
        ge = err_sig; at = cyc;
        break;
      end
    end
    if (to) begin
      @(negedge clk);
      wv = 1'b0; rv = 1'b0;
      return;
    end
    @(negedge clk);
    if (hold == 0) drop(gw);
    @(posedge clk); #1;
    nar = !rrv && !wrv && (rdata === 32'h0);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      drop(gw);
    end
  endtask

  task automatic run_one(input op_t o, input int hold,
                         output tup_t act,
                         output tup_t exp,
                         output bit to);
    int acc, at;
    logic gw, ge, nar;
    logic [31:0] gd;
    @(negedge clk);
    issue(o);
    acc = cyc + 1;
    wait_resp(hold, gw, gd, ge, at, nar, to);
    act = {gw, gd, ge, 4'(at - acc + 1), nar};
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = 'x;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (rrv !== 1'b0) begin
      fails++;
      $display("FAIL rst_rvalid: got %b want 0", rrv);
    end
    tests++;
    if (wrv !== 1'b0) begin
      fails++;
      $display("FAIL rst_wvalid: got %b want 0", wrv);
    end
    tests++;
    if (rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_rdata: got %h want 0", rdata);
    end
    tests++;
    if (err_sig !== 1'b0) begin
      fails++;
      $display("FAIL rst_err: got %b want 0", err_sig);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word();
    op_t  ops[5];
    tup_t act, exp;
    bit   to;
    ops = '{W(32'h00, 32'h1111_1111, F, 1'b0),
            W(32'h20, 32'h0, F, 1'b0),
            W(32'h14, 32'h0, F, 1'b0),
            W(32'h10, 32'hDEAD_BEEF, F, 1'b0),
            R(32'h10, F, 32'hDEAD_BEEF, 1'b0)};
    foreach (ops[i]) begin
      run_one(ops[i], 0, act, exp, to);
      tests++;
      if (to || act !== exp) begin
        fails++;
        $display("FAIL word[%0d]: got %h want %h to=%0b",
                 i, act, exp, to);
      end
    end
  endtask

  task automatic test_byte_lane();
    op_t  ops[8];
    tup_t act, exp;
    bit   to;
    ops = '{W(32'h12, 32'h55, MEM_MASK_B, 1'b0),
            R(32'h10, F, 32'hDE55_BEEF, 1'b0),
            R(32'h13, MEM_MASK_B, 32'h0000_00DE, 1'b0),
            R(32'h12, MEM_MASK_H, 32'h0000_DE55, 1'b0),
            W(32'h16, 32'h1234, MEM_MASK_H, 1'b0),
            R(32'h14, F, 32'h1234_0000, 1'b0),
            W(32'h14, 32'hFFFF_FF77, MEM_MASK_B, 1'b0),
            R(32'h14, F, 32'h1234_0077, 1'b0)};
    foreach (ops[i]) begin
      run_one(ops[i], 0, act, exp, to);
      tests++;
      if (to || act !== exp) begin
        fails++;
        $display("FAIL bytes[%0d]: got %h want %h to=%0b",
                 i, act, exp, to);
      end
    end
  endtask

  task automatic test_misalign_range();
    op_t  ops[10];
    tup_t act, exp;
    bit   to;
    ops = '{W(32'h21, 32'h1122_3344, F, ERR),
            R(32'h20, F, ERR ? 32'h0 : 32'h2233_4400, 1'b0),
            R(32'h22, F, ERR ? 32'h0 : 32'h0000_2233, ERR),
            R(32'h11, MEM_MASK_H,
              ERR ? 32'h0 : 32'h00DE_55BE, ERR),
            R(32'h11, MEM_MASK_B, 32'h00DE_55BE, 1'b0),
            R(OOR, F, 32'h0, ERR),
            W(OOR, 32'h9999_9999, F, ERR),
            R(32'h00, F, 32'h1111_1111, 1'b0),
            W(OOR - 4, 32'hA1B2_C3D4, F, 1'b0),
            R(OOR - 4, F, 32'hA1B2_C3D4, 1'b0)};
    foreach (ops[i]) begin
      run_one(ops[i], 0, act, exp, to);
      tests++;
      if (to || act !== exp) begin
        fails++;
        $display("FAIL edge[%0d]: got %h want %h to=%0b",
                 i, act, exp, to);
      end
    end
  endtask

  task automatic test_priority();
    tup_t act, exp;
    bit   to;
    int   acc, at;
    logic gw, ge, nar;
    logic [31:0] gd;
    @(negedge clk);
    issue(W(32'h30, 32'hCAFE_F00D, F, 1'b0));
    issue(R(32'h30, F, 32'hCAFE_F00D, 1'b0));
    acc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      wait_resp(0, gw, gd, ge, at, nar, to);
      act = {gw, gd, ge, 4'(at - acc + 1), nar};
      if (sb.size() > 0) exp = sb.pop_front();
      else exp = 'x;
      tests++;
      if (to || act !== exp) begin
        fails++;
        $display("FAIL prio[%0d]: got %h want %h to=%0b",
                 k, act, exp, to);
      end
      // read accepted on the IDLE edge after RESP
      acc = at + 2;
    end
  endtask

  task automatic test_hold();
    op_t  o;
    tup_t act, exp;
    bit   to;
    int   base;
    for (int k = 0; k < 2; k++) begin
      o = (k == 0) ? W(32'h44, 32'h5A5A_5A5A, F, 1'b0)
                   : R(32'h44, F, 32'h5A5A_5A5A, 1'b0);
      base = n_rr + n_wr;
      run_one(o, 2, act, exp, to);
      tests++;
      if (to || act !== exp) begin
        fails++;
        $display("FAIL hold[%0d]: got %h want %h to=%0b",
                 k, act, exp, to);
      end
      repeat (8) @(negedge clk);
      tests++;
      if (n_rr + n_wr - base !== 1) begin
        fails++;
        $display("FAIL hold_pulses[%0d]: got %0d want 1",
                 k, n_rr + n_wr - base);
      end
    end
  endtask

  task automatic test_reset_mid();
    op_t  ops[2];
    tup_t act, exp;
    bit   to;
    int   base;
    base = n_rr;
    @(negedge clk);
    rv = 1'b1; raddr = 32'h10; wmask = F;
    @(negedge clk);
    rst = 1'b1; rv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (n_rr - base !== 0) begin
      fails++;
      $display("FAIL rstmid_rd: got %0d pulses want 0",
               n_rr - base);
    end
    base = n_wr;
    @(negedge clk);
    wv = 1'b1; waddr = 32'h40;
    wdata = 32'h0BAD_F00D; wmask = F;
    @(negedge clk);
    rst = 1'b1; wv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (n_wr - base !== 0) begin
      fails++;
      $display("FAIL rstmid_wr: got %0d pulses want 0",
               n_wr - base);
    end
    ops = '{R(32'h40, F, 32'h0BAD_F00D, 1'b0),
            R(32'h10, F, 32'hDE55_BEEF, 1'b0)};
    foreach (ops[i]) begin
      run_one(ops[i], 0, act, exp, to);
      tests++;
      if (to || act !== exp) begin
        fails++;
        $display("FAIL rstmid[%0d]: got %h want %h to=%0b",
                 i, act, exp, to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lane();
    test_misalign_range();
    test_priority();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
